memsync_arbiter: RTL and testbench
==================================

Name: memsync_arbiter

Overview:
- Shares one MEMSync row-cache controller among NBANKS bank FSMs.
- Round-robin selects one pending RD/WR request and forwards RD/WR/RowId to the cache.
- Holds the request until the cache reports ready, returns a one-cycle ready pulse to the winning bank, then waits for the cache to return to idle before re-arbitrating.
- Reflects cache stall back to the granted bank.

Parameters:
- NBANKS, 4, number of requesting bank FSMs (≥2).
- ADDRWIDTH, 17, row address width; matches the cache's RowId.
- GW, $clog2(NBANKS), grant index width (derived localparam).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- bank_rd  in  NBANKS  per-bank read request; held until bank_ready
- bank_wr  in  NBANKS  per-bank write request; held until bank_ready
- bank_rowid  in  NBANKS*ADDRWIDTH  packed row addresses; bank i at [i*ADDRWIDTH +: ADDRWIDTH]
- bank_ready  out  NBANKS  one-cycle completion pulse to the granted bank
- bank_stall  out  NBANKS  cache_stall routed to the granted bank
- grant_id  out  GW  index of the current or last granted bank
- busy  out  1  high in every state except IDLE
- cache_RD  out  1  read request to the cache
- cache_WR  out  1  write request to the cache
- cache_RowId  out  ADDRWIDTH  row address to the cache
- cache_ready  in  1  cache ready (hitRD/hitWR)
- cache_stall  in  1  cache stall (Allocate/WriteBack)
- cache_hit  in  1  cache hit indication

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state IDLE; all outputs 0; round-robin pointer last = NBANKS-1, so bank 0 has first priority.
- Pending bank i: bank_rd[i] | bank_wr[i].
- Registered outputs: all except bank_stall. bank_stall[i] = cache_stall & (state == ISSUE) & (grant_id == i), combinational.
- State IDLE:
  - If any bank is pending, select the first pending index searching last+1, last+2, … with wrap modulo NBANKS.
  - Latch grant_id, cache_RowId from that bank's field, cache_RD = bank_rd[g], cache_WR = bank_wr[g] & ~bank_rd[g] (read wins when both are set).
  - Go to ISSUE. Arbitration-to-cache latency is 1 cycle.
- State ISSUE:
  - Hold cache_RD/WR/RowId stable; they are latched and later bank input changes are ignored.
  - On cache_ready = 1: clear cache_RD and cache_WR, pulse bank_ready[grant_id] for exactly 1 cycle, go to COOL.
- State COOL:
  - cache_RD/WR stay 0.
  - Wait until cache_ready = 0, meaning the cache has left hitRD/hitWR.
  - Then set last = grant_id and go to IDLE.
  - A minimum of 1 COOL cycle is always spent, so back-to-back grants are separated by at least 2 cycles with RD/WR low.
- Requester contract: a bank drops its request in the cycle after its bank_ready pulse. If it is still asserted in IDLE, it is treated as a new request and competes normally; round-robin places it last.
- Starvation: with all NBANKS continuously pending, grants rotate 0,1,2,3,0,…
- Simultaneous events: a new request arriving during ISSUE/COOL waits. A request dropped by a non-granted bank before IDLE is never served.
- Reset mid-transaction: immediate return to IDLE with cache_RD/WR = 0. No bank_ready is issued; the cache is reset by the same rst.
- grant_id holds its value through IDLE (last grant) and is only meaningful while busy.

Optional Feature:
- Macro MEMSYNC_ARB_PERF_EN.
- Defined: adds outputs perf_hits[31:0] and perf_misses[31:0], reset to 0.
  - On each ISSUE→COOL transition, increment perf_misses if cache_stall was seen high during that ISSUE; otherwise increment perf_hits.
  - Counters saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, then bank 2 raises bank_rd with rowid 0x00A5 → next cycle cache_RD = 1, cache_RowId = 0x00A5, grant_id = 2, busy = 1. Model raises cache_ready 3 cycles later → bank_ready[2] pulses 1 cycle, cache_RD = 0 on the same edge.
- Banks 0–3 all assert bank_wr continuously, model acks each → grant order 0,1,2,3,0. cache_WR is low for ≥2 cycles between grants.
- Bank 1 asserts rd and wr together → cache_RD = 1, cache_WR = 0.
- Miss: model holds cache_stall = 1 for 10 cycles during ISSUE → bank_stall[g] = 1 for those cycles only, other bits 0. With MEMSYNC_ARB_PERF_EN, perf_misses = 1, perf_hits = 0 afterwards.
- Model holds cache_ready = 1 for 3 cycles after RD drops → arbiter stays in COOL until it falls; no new grant occurs despite bank 3 pending.
- Assert rst during ISSUE → within the same cycle cache_RD/WR = 0, busy = 0, no bank_ready pulse. After release, bank 0 wins over bank 3 when both are pending.

Source files
------------

// File: rtl/memsync_arbiter.sv
// rtl/memsync_arbiter.sv - round-robin arbiter sharing one MEMSync row cache among bank FSMs
//
// Optional build macro: MEMSYNC_ARB_PERF_EN (adds perf_hits / perf_misses counters)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bank_rd, bank_wr    per-bank requests, held by the bank until bank_ready
//   bank_rowid          packed per-bank row addresses, bank i at [i*ADDRWIDTH +: ADDRWIDTH]
//   bank_ready          one-cycle completion pulse to the granted bank
//   bank_stall          cache_stall routed to the granted bank while issuing
//   grant_id            current / last granted bank index
//   busy                high whenever not IDLE
//   cache_RD/WR/RowId   request to the row cache
//   cache_ready/stall/hit  status from the row cache
//   perf_hits/misses    (MEMSYNC_ARB_PERF_EN only) saturating transaction counters
module memsync_arbiter #(
    parameter int NBANKS    = 4,
    parameter int ADDRWIDTH = 17,
    localparam int GW       = $clog2(NBANKS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NBANKS-1:0]           bank_rd,
    input  logic [NBANKS-1:0]           bank_wr,
    input  logic [NBANKS*ADDRWIDTH-1:0] bank_rowid,
    output logic [NBANKS-1:0]           bank_ready,
    output logic [NBANKS-1:0]           bank_stall,
    output logic [GW-1:0]               grant_id,
    output logic                        busy,
    output logic                        cache_RD,
    output logic                        cache_WR,
    output logic [ADDRWIDTH-1:0]        cache_RowId,
    input  logic                        cache_ready,
    input  logic                        cache_stall,
    input  logic                        cache_hit
`ifdef MEMSYNC_ARB_PERF_EN
    ,
    output logic [31:0]                 perf_hits,
    output logic [31:0]                 perf_misses
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] COOL  = 2'd2;

    logic [1:0]        state;
    logic [GW-1:0]     last;
    logic [NBANKS-1:0] pend;
    logic              any_pend;
    logic [GW-1:0]     sel;

    // The cache reports hit/miss through ready/stall timing; the hit flag itself is not needed.
    logic unused_hit;
    assign unused_hit = cache_hit;

    assign pend = bank_rd | bank_wr;

    // Search last+1, last+2, ... with wrap. Walking the offsets from far to near and
    // overwriting leaves the nearest pending bank as the winner.
    always_comb begin
        any_pend = 1'b0;
        sel      = '0;
        for (int k = NBANKS; k >= 1; k--) begin
            int idx;
            idx = (int'(last) + k) % NBANKS;
            if (pend[idx]) begin
                any_pend = 1'b1;
                sel      = GW'(idx);
            end
        end
    end

    always_comb begin
        bank_stall = '0;
        for (int i = 0; i < NBANKS; i++) begin
            bank_stall[i] = cache_stall && (state == ISSUE) && (grant_id == GW'(i));
        end
    end

`ifdef MEMSYNC_ARB_PERF_EN
    logic stall_seen;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last        <= GW'(NBANKS - 1);
            grant_id    <= '0;
            busy        <= 1'b0;
            cache_RD    <= 1'b0;
            cache_WR    <= 1'b0;
            cache_RowId <= '0;
            bank_ready  <= '0;
`ifdef MEMSYNC_ARB_PERF_EN
            stall_seen  <= 1'b0;
            perf_hits   <= '0;
            perf_misses <= '0;
`endif
        end else begin
            bank_ready <= '0;
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        grant_id    <= sel;
                        cache_RowId <= bank_rowid[int'(sel)*ADDRWIDTH +: ADDRWIDTH];
                        cache_RD    <= bank_rd[sel];
                        // Read wins when a bank raises both.
                        cache_WR    <= bank_wr[sel] & ~bank_rd[sel];
                        busy        <= 1'b1;
                        state       <= ISSUE;
`ifdef MEMSYNC_ARB_PERF_EN
                        stall_seen  <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
`ifdef MEMSYNC_ARB_PERF_EN
                    if (cache_stall) begin
                        stall_seen <= 1'b1;
                    end
`endif
                    if (cache_ready) begin
                        cache_RD   <= 1'b0;
                        cache_WR   <= 1'b0;
                        bank_ready <= {{(NBANKS-1){1'b0}}, 1'b1} << grant_id;
                        state      <= COOL;
`ifdef MEMSYNC_ARB_PERF_EN
                        // Include the stall seen on the completing cycle itself.
                        if (stall_seen || cache_stall) begin
                            if (perf_misses != 32'hFFFF_FFFF) begin
                                perf_misses <= perf_misses + 32'd1;
                            end
                        end else begin
                            if (perf_hits != 32'hFFFF_FFFF) begin
                                perf_hits <= perf_hits + 32'd1;
                            end
                        end
`endif
                    end
                end
                COOL: begin
                    // Wait for the cache to leave hitRD/hitWR before the next grant.
                    if (!cache_ready) begin
                        last  <= grant_id;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    cache_RD <= 1'b0;
                    cache_WR <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memsync_arbiter.sv
// tb/tb_memsync_arbiter.sv - directed self-checking bench for memsync_arbiter
module tb_memsync_arbiter;

    localparam int NB = 4;
    localparam int AW = 17;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NB-1:0]     bank_rd;
    logic [NB-1:0]     bank_wr;
    logic [NB*AW-1:0]  bank_rowid;
    logic [NB-1:0]     bank_ready;
    logic [NB-1:0]     bank_stall;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic              cache_RD;
    logic              cache_WR;
    logic [AW-1:0]     cache_RowId;
    logic              cache_ready;
    logic              cache_stall;
    logic              cache_hit;
`ifdef MEMSYNC_ARB_PERF_EN
    logic [31:0]       perf_hits;
    logic [31:0]       perf_misses;
`endif

    int errors = 0;
    int checks = 0;

    memsync_arbiter #(.NBANKS(NB), .ADDRWIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bank_rd     (bank_rd),
        .bank_wr     (bank_wr),
        .bank_rowid  (bank_rowid),
        .bank_ready  (bank_ready),
        .bank_stall  (bank_stall),
        .grant_id    (grant_id),
        .busy        (busy),
        .cache_RD    (cache_RD),
        .cache_WR    (cache_WR),
        .cache_RowId (cache_RowId),
        .cache_ready (cache_ready),
        .cache_stall (cache_stall),
        .cache_hit   (cache_hit)
`ifdef MEMSYNC_ARB_PERF_EN
        ,
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_row(input int i, input logic [AW-1:0] v);
        bank_rowid[i*AW +: AW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Wait for a grant, check it, acknowledge it. n returns the low cycles waited.
    task automatic serve(input string tag, input int g, input logic erd, input logic ewr,
                         input logic hold, output int n);
        logic [AW-1:0] row;
        row = bank_rowid[g*AW +: AW];
        n = 0;
        while (!(cache_RD || cache_WR) && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < 20), 64'd1);
        chk({tag, "_grant"}, 64'(grant_id), 64'(g));
        chk({tag, "_rd"}, 64'(cache_RD), 64'(erd));
        chk({tag, "_wr"}, 64'(cache_WR), 64'(ewr));
        chk({tag, "_row"}, 64'(cache_RowId), 64'(row));
        cache_ready = 1'b1;
        tick();
        chk({tag, "_ready"}, 64'(bank_ready), 64'(4'b0001 << g));
        chk({tag, "_drop"}, 64'(cache_RD | cache_WR), 64'd0);
        if (!hold) cache_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        bank_rd     = '0;
        bank_wr     = '0;
        bank_rowid  = '0;
        cache_ready = 1'b0;
        cache_stall = 1'b0;
        cache_hit   = 1'b0;
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd", 64'(cache_RD), 64'd0);
        chk("rst_wr", 64'(cache_WR), 64'd0);
        chk("rst_ready", 64'(bank_ready), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_row", 64'(cache_RowId), 64'd0);
        rst = 1'b0;

        // Single read from bank 2, ack three cycles after issue.
        bank_rd[2] = 1'b1;
        set_row(2, 17'h00A5);
        tick();
        chk("t1_rd", 64'(cache_RD), 64'd1);
        chk("t1_row", 64'(cache_RowId), 64'h00A5);
        chk("t1_grant", 64'(grant_id), 64'd2);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_wr", 64'(cache_WR), 64'd0);
        tick();
        tick();
        chk("t1_hold_rd", 64'(cache_RD), 64'd1);
        chk("t1_noready", 64'(bank_ready), 64'd0);
        cache_ready = 1'b1;
        tick();
        chk("t1_ready", 64'(bank_ready), 64'b0100);
        chk("t1_rd_drop", 64'(cache_RD), 64'd0);
        bank_rd[2]  = 1'b0;
        cache_ready = 1'b0;
        tick();
        chk("t1_pulse_end", 64'(bank_ready), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);
        chk("t1_grant_held", 64'(grant_id), 64'd2);

        // All banks writing continuously: rotation 0,1,2,3,0 with gaps.
        do_reset();
        for (int i = 0; i < NB; i++) set_row(i, 17'(17'h100 + i));
        bank_wr = 4'hF;
        for (int k = 0; k < 5; k++) begin
            serve($sformatf("t2_g%0d", k), k % NB, 1'b0, 1'b1, 1'b0, n);
            if (k > 0) chk($sformatf("t2_gap%0d", k), 64'(n + 1 >= 2), 64'd1);
        end
        bank_wr = '0;
        tick();

        // Read and write together: read wins.
        bank_rd[1] = 1'b1;
        bank_wr[1] = 1'b1;
        set_row(1, 17'h1ABCD);
        serve("t3", 1, 1'b1, 1'b0, 1'b0, n);
        bank_rd = '0;
        bank_wr = '0;
        tick();

        // Miss: stall routed only to the granted bank while issuing.
        do_reset();
`ifdef MEMSYNC_ARB_PERF_EN
        chk("t4_hits0", 64'(perf_hits), 64'd0);
        chk("t4_miss0", 64'(perf_misses), 64'd0);
`endif
        bank_rd[0] = 1'b1;
        set_row(0, 17'h00F0);
        tick();
        chk("t4_grant", 64'(grant_id), 64'd0);
        chk("t4_nostall", 64'(bank_stall), 64'd0);
        for (int i = 0; i < 10; i++) begin
            cache_stall = 1'b1;
            #1;
            chk($sformatf("t4_stall%0d", i), 64'(bank_stall), 64'b0001);
            tick();
        end
        cache_stall = 1'b0;
        #1;
        chk("t4_stall_end", 64'(bank_stall), 64'd0);
        cache_ready = 1'b1;
        tick();
        chk("t4_ready", 64'(bank_ready), 64'b0001);
        bank_rd     = '0;
        cache_ready = 1'b0;
        cache_stall = 1'b1;
        #1;
        chk("t4_cool_nostall", 64'(bank_stall), 64'd0);
        cache_stall = 1'b0;
        tick();
`ifdef MEMSYNC_ARB_PERF_EN
        chk("t4_hits", 64'(perf_hits), 64'd0);
        chk("t4_miss", 64'(perf_misses), 64'd1);
`endif

        // cache_ready lingering keeps the arbiter in COOL despite bank 3 pending.
        bank_rd[1] = 1'b1;
        bank_rd[3] = 1'b1;
        set_row(3, 17'h00333);
        serve("t5", 1, 1'b1, 1'b0, 1'b1, n);
        bank_rd[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_cool_busy%0d", i), 64'(busy), 64'd1);
            chk($sformatf("t5_cool_rd%0d", i), 64'(cache_RD), 64'd0);
            chk($sformatf("t5_cool_grant%0d", i), 64'(grant_id), 64'd1);
        end
        cache_ready = 1'b0;
        tick();
        chk("t5_idle", 64'(busy), 64'd0);
        tick();
        chk("t5_grant3", 64'(grant_id), 64'd3);
        chk("t5_rd3", 64'(cache_RD), 64'd1);
        chk("t5_row3", 64'(cache_RowId), 64'h00333);
        cache_ready = 1'b1;
        tick();
        chk("t5_ready3", 64'(bank_ready), 64'b1000);
        bank_rd     = '0;
        cache_ready = 1'b0;
        tick();
`ifdef MEMSYNC_ARB_PERF_EN
        chk("t5_hits", 64'(perf_hits), 64'd2);
        chk("t5_miss", 64'(perf_misses), 64'd1);
`endif

        // Reset during ISSUE, then bank 0 beats bank 3.
        bank_rd[2] = 1'b1;
        tick();
        chk("t6_issue", 64'(cache_RD), 64'd1);
        chk("t6_grant", 64'(grant_id), 64'd2);
        rst = 1'b1;
        #1;
        chk("t6_rst_rd", 64'(cache_RD), 64'd0);
        chk("t6_rst_wr", 64'(cache_WR), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_ready", 64'(bank_ready), 64'd0);
        bank_rd = 4'b1001;
        tick();
        chk("t6_rst_ready2", 64'(bank_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("t6_win0", 64'(grant_id), 64'd0);
        chk("t6_win_rd", 64'(cache_RD), 64'd1);
        cache_ready = 1'b1;
        tick();
        chk("t6_ready0", 64'(bank_ready), 64'b0001);
        bank_rd     = '0;
        cache_ready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
